// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// bit-time helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_START_BIT       = 3'd1,
        ST_DATA_BITS       = 3'd2,
        ST_STOP_BIT        = 3'd3,
        ST_WAIT_FOR_GO_LOW = 3'd4
    } state_e;

    // Clock cycles per line bit (integer division).
    function automatic int unsigned bit_time(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter: sends one byte per go/done handshake as 8N1 or 8N2.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   data  - byte to send, captured when go is accepted in Idle
//   go    - raise to start a frame, drop to acknowledge done
//   tx    - serial line, idles high
//   busy  - high while the frame is on the line
//   done  - high once the stop bits have completed, held until go drops
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned ClockFrequencyHz = 66_000_000,
    parameter int unsigned BaudRate         = 9600,
    parameter int unsigned StopBits         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 go,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BIT_TIME = bit_time(ClockFrequencyHz, BaudRate);
    // The counter also holds BIT_TIME (start-bit lead-in) and the full stop period.
    localparam int unsigned CNT_MAX  = StopBits * BIT_TIME;
    localparam int unsigned CNT_W    = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);

    if (BIT_TIME < 1) begin : g_bad_bit_time
        $error("uart_tx: ClockFrequencyHz / BaudRate must be at least 1");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
        $error("uart_tx: StopBits must be 1 or 2");
    end

    state_e               r_state, w_state_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;

        unique case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (go) begin
                    w_shift_nxt = data;
                    // One extra count so the line falls on the following edge.
                    w_cnt_nxt   = CNT_W'(BIT_TIME);
                    w_state_nxt = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (r_cnt == CNT_W'(BIT_TIME)) begin
                    w_tx_nxt   = 1'b0;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else if (r_cnt == '0) begin
                    w_tx_nxt    = r_shift[0];
                    w_cnt_nxt   = CNT_W'(BIT_TIME - 1);
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA_BITS;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DATA_BITS: begin
                if (r_cnt == '0) begin
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_tx_nxt    = 1'b1;
                        w_cnt_nxt   = CNT_W'(StopBits * BIT_TIME - 1);
                        w_state_nxt = ST_STOP_BIT;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_cnt_nxt   = CNT_W'(BIT_TIME - 1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_STOP_BIT: begin
                if (r_cnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_WAIT_FOR_GO_LOW;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_WAIT_FOR_GO_LOW: begin
                w_tx_nxt = 1'b1;
                // go must fall before another frame can start.
                if (!go) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: four instances cover
// BIT_TIME=10 with one and two stop bits, BIT_TIME=1, and 66 MHz/115200.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] go;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] data [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx #(.ClockFrequencyHz(20), .BaudRate(2), .StopBits(1)) u_dut0 (
        .clk(clk), .rst(rst), .data(data[0]), .go(go[0]),
        .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx #(.ClockFrequencyHz(20), .BaudRate(2), .StopBits(2)) u_dut1 (
        .clk(clk), .rst(rst), .data(data[1]), .go(go[1]),
        .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx #(.ClockFrequencyHz(20), .BaudRate(20), .StopBits(1)) u_dut2 (
        .clk(clk), .rst(rst), .data(data[2]), .go(go[2]),
        .tx(tx[2]), .busy(busy[2]), .done(done[2]));
    uart_tx #(.ClockFrequencyHz(66_000_000), .BaudRate(115200), .StopBits(1)) u_dut3 (
        .clk(clk), .rst(rst), .data(data[3]), .go(go[3]),
        .tx(tx[3]), .busy(busy[3]), .done(done[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Sends one byte and checks every line cycle against the 8N1/8N2 frame,
    // a mid-bit sampled receive of the byte, and the done/busy handshake.
    // drop_at >= 0 clears data and go that many cycles into the frame.
    task automatic send_frame(input int idx, input logic [7:0] b, input int bt,
                              input int ns, input int drop_at, input string tag);
        int         bad = 0;
        int         cyc = 0;
        logic [7:0] rx  = 8'h00;
        logic       e;
        data[idx] = b;
        go[idx]   = 1'b1;
        @(negedge clk);
        check({tag, "_latency"}, 32'(tx[idx]), 32'd1);
        for (int p = 0; p < 9 + ns; p++) begin
            for (int j = 0; j < bt; j++) begin
                @(negedge clk);
                cyc++;
                e = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
                if (tx[idx] !== e || busy[idx] !== 1'b1 || done[idx] !== 1'b0) bad++;
                if (p >= 1 && p <= 8 && j == bt / 2) rx[p-1] = tx[idx];
                if (cyc == drop_at) begin
                    data[idx] = 8'h00;
                    go[idx]   = 1'b0;
                end
            end
        end
        check({tag, "_line"}, 32'(bad), 32'd0);
        check({tag, "_rx"}, 32'(rx), 32'(b));
        @(negedge clk);
        check({tag, "_done"}, 32'(done[idx]), 32'd1);
        check({tag, "_busy_end"}, 32'(busy[idx]), 32'd0);
        if (drop_at >= 0) begin
            @(negedge clk);
            check({tag, "_done_clr"}, 32'(done[idx]), 32'd0);
        end
    endtask

    // Acknowledge done and confirm it clears one cycle later.
    task automatic ack(input int idx, input string tag);
        go[idx] = 1'b0;
        @(negedge clk);
        check({tag, "_ack"}, 32'(done[idx]), 32'd0);
    endtask

    initial begin
        int bad;
        logic [7:0] b;
        rst = 1'b1;
        go  = 4'h0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 32'hF);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 4'hF || busy !== 4'h0 || done !== 4'h0) bad++;
        end
        check("idle_50", 32'(bad), 32'd0);

        send_frame(0, 8'hA5, 10, 1, -1, "a5");
        ack(0, "a5");

        send_frame(1, 8'h00, 10, 2, -1, "s2_00");
        ack(1, "s2_00");
        send_frame(1, 8'hFF, 10, 2, -1, "s2_ff");
        ack(1, "s2_ff");

        // go held high after done must not retransmit.
        send_frame(0, 8'h5A, 10, 1, -1, "hold");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b1) bad++;
        end
        check("hold_no_retx", 32'(bad), 32'd0);
        ack(0, "hold");
        send_frame(0, 8'h3C, 10, 1, -1, "x3c");
        ack(0, "x3c");

        send_frame(0, 8'hA5, 10, 1, 30, "drop");

        send_frame(2, 8'h96, 1, 1, -1, "bt1_96");
        ack(2, "bt1_96");
        send_frame(2, 8'h01, 1, 1, -1, "bt1_01");
        ack(2, "bt1_01");

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(3, b, 572, 1, -1, $sformatf("lb%0d", i));
            ack(3, $sformatf("lb%0d", i));
        end

        // Reset 30 cycles into a frame, while the line is low.
        data[0] = 8'hA5;
        go[0]   = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_rst_tx", 32'(tx[0]), 32'd0);
        go[0] = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx[0]), 32'd1);
        check("rst_async_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
        end
        check("rst_abandon", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_uart_tx
